// File: rtl/fifomem_pipe.sv
// FIFO storage array: lane-masked writes, optional same-address write-first bypass,
// per-entry written bitmap and a 1- or 2-stage registered read pipeline.
module fifomem_pipe #(
    parameter int unsigned Data_size = 8,
    parameter int unsigned Addr_size = 9,
    parameter int unsigned Lane_size = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                           w_clk,
    input  logic                           w_rst,
    input  logic                           w_inc,
    input  logic                           w_full,
    input  logic [Addr_size-1:0]           waddr,
    input  logic [Data_size-1:0]           wdata,
    input  logic [Data_size/Lane_size-1:0] wbe,
    input  logic                           r_inc,
    input  logic                           r_empty,
    input  logic [Addr_size-1:0]           raddr,
    output logic [Data_size-1:0]           rdata,
    output logic                           rvalid,
    output logic                           r_uninit
);
    localparam int unsigned Lanes = Data_size / Lane_size;
    localparam int unsigned Depth = 1 << Addr_size;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "fifomem_pipe: RD_LAT must be 1 or 2");
    end
    if (Data_size % Lane_size != 0) begin : g_bad_lane
        $fatal(1, "fifomem_pipe: Data_size must be a multiple of Lane_size");
    end

    logic [Data_size-1:0] mem_q [Depth];
    logic [Depth-1:0]     written_q;
    logic [Depth-1:0]     written_d;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 wr_any;
    logic                 rd_hit;
    logic [Data_size-1:0] lane_mask;
    logic [Data_size-1:0] rd_word;
    logic                 rd_uninit;

    // Accept gating, lane mask expansion, bypass merge and bitmap update
    always_comb begin
        wr_acc    = w_inc && !w_full && !w_rst;
        rd_acc    = r_inc && !r_empty && !w_rst;
        wr_any    = |wbe;
        lane_mask = '0;
        for (int unsigned i = 0; i < Lanes; i++) begin
            lane_mask[i*Lane_size +: Lane_size] = {Lane_size{wbe[i]}};
        end
        rd_hit    = BYPASS && wr_acc && wr_any && (waddr == raddr);
        rd_word   = mem_q[raddr];
        rd_uninit = !written_q[raddr];
        if (rd_hit) begin
            rd_word   = (rd_word & ~lane_mask) | (wdata & lane_mask);
            rd_uninit = 1'b0;
        end
        written_d = written_q;
        if (wr_acc && wr_any) begin
            written_d[waddr] = 1'b1;
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge w_clk) begin
        if (wr_acc && wr_any) begin
            mem_q[waddr] <= (mem_q[waddr] & ~lane_mask) | (wdata & lane_mask);
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    logic                 pipe_v;
    logic                 pipe_u;
    logic [Data_size-1:0] pipe_d;

    if (RD_LAT == 2) begin : g_lat2
        logic                 s1_valid_q, s1_valid_d;
        logic                 s1_uninit_q, s1_uninit_d;
        logic [Data_size-1:0] s1_data_q, s1_data_d;

        always_comb begin
            s1_valid_d  = rd_acc;
            s1_data_d   = s1_data_q;
            s1_uninit_d = s1_uninit_q;
            if (rd_acc) begin
                s1_data_d   = rd_word;
                s1_uninit_d = rd_uninit;
            end
        end

        always_ff @(posedge w_clk) begin
            if (w_rst) begin
                s1_valid_q  <= 1'b0;
                s1_data_q   <= '0;
                s1_uninit_q <= 1'b0;
            end else begin
                s1_valid_q  <= s1_valid_d;
                s1_data_q   <= s1_data_d;
                s1_uninit_q <= s1_uninit_d;
            end
        end

        assign pipe_v = s1_valid_q;
        assign pipe_d = s1_data_q;
        assign pipe_u = s1_uninit_q;
    end else begin : g_lat1
        assign pipe_v = rd_acc;
        assign pipe_d = rd_word;
        assign pipe_u = rd_uninit;
    end

    logic                 rvalid_q, rvalid_d;
    logic                 r_uninit_q, r_uninit_d;
    logic [Data_size-1:0] rdata_q, rdata_d;

    // Output stage: rdata and r_uninit hold between accepted reads
    always_comb begin
        rvalid_d   = pipe_v;
        rdata_d    = rdata_q;
        r_uninit_d = r_uninit_q;
        if (pipe_v) begin
            rdata_d    = pipe_d;
            r_uninit_d = pipe_u;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            r_uninit_q <= 1'b0;
        end else begin
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            r_uninit_q <= r_uninit_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign r_uninit = r_uninit_q;

endmodule

// File: tb/tb_fifomem_pipe.sv
// Bench for fifomem_pipe: three configurations share one stimulus stream and are
// checked every cycle against a queue-based model, plus directed literal checks.
module tb_fifomem_pipe;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          w_rst, w_inc, w_full, r_inc, r_empty;
    logic [AW-1:0] waddr, raddr;
    logic [15:0]   wdata;
    logic [1:0]    wbe;
    logic [7:0]    rdata_a;
    logic [15:0]   rdata_b, rdata_c;
    logic          rvalid_a, rvalid_b, rvalid_c;
    logic          runinit_a, runinit_b, runinit_c;

    // a: 8-bit, latency 1, write-first
    fifomem_pipe #(.Data_size(8), .Addr_size(AW), .Lane_size(8), .RD_LAT(1), .BYPASS(1'b1)) dut_a (
        .w_clk(clk), .w_rst(w_rst), .w_inc(w_inc), .w_full(w_full), .waddr(waddr),
        .wdata(wdata[7:0]), .wbe(wbe[0:0]), .r_inc(r_inc), .r_empty(r_empty), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a), .r_uninit(runinit_a));
    // b: 16-bit, two lanes, latency 2, read-first
    fifomem_pipe #(.Data_size(16), .Addr_size(AW), .Lane_size(8), .RD_LAT(2), .BYPASS(1'b0)) dut_b (
        .w_clk(clk), .w_rst(w_rst), .w_inc(w_inc), .w_full(w_full), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .r_inc(r_inc), .r_empty(r_empty), .raddr(raddr),
        .rdata(rdata_b), .rvalid(rvalid_b), .r_uninit(runinit_b));
    // c: 16-bit, two lanes, latency 1, write-first
    fifomem_pipe #(.Data_size(16), .Addr_size(AW), .Lane_size(8), .RD_LAT(1), .BYPASS(1'b1)) dut_c (
        .w_clk(clk), .w_rst(w_rst), .w_inc(w_inc), .w_full(w_full), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .r_inc(r_inc), .r_empty(r_empty), .raddr(raddr),
        .rdata(rdata_c), .rvalid(rvalid_c), .r_uninit(runinit_c));

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string what, input logic [15:0] act, input logic [15:0] exp,
                         input logic [15:0] mask);
        n_chk++;
        if (((act ^ exp) & mask) !== 16'h0) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", what, act, exp, mask, $time);
        end
    endtask

    task automatic lit(input string what, input logic [15:0] act, input logic [15:0] exp);
        check(what, act, exp, 16'hFFFF);
    endtask

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic bit byp_of(input int k);
        return k != 1;
    endfunction

    // Model: words per config, mask of lanes with known content, written flags, and
    // a queue of pending results each tagged with the edge at which it becomes visible.
    typedef struct {
        int          due;
        logic [15:0] d;
        logic [15:0] kn;
        bit          u;
    } ent_t;

    logic [15:0] m_mem [3][DEPTH];
    logic [15:0] m_kn  [3][DEPTH];
    bit          m_wr  [3][DEPTH];
    ent_t        pend  [3][$];
    bit          ev [3];
    logic [15:0] ed [3];
    logic [15:0] ek [3];
    bit          eu [3];
    int          cyc_n = 0;

    always @(posedge clk) begin
        cyc_n++;
        for (int k = 0; k < 3; k++) begin
            logic [15:0] wm, dm, d, kn;
            bit          u;
            ent_t        e;
            dm = (k == 0) ? 16'h00FF : 16'hFFFF;
            wm = {{8{wbe[1] && (k != 0)}}, {8{wbe[0]}}};
            if (w_rst) begin
                for (int a = 0; a < DEPTH; a++) m_wr[k][a] = 1'b0;
                pend[k].delete();
                ev[k] = 1'b0; ed[k] = 16'h0; ek[k] = dm; eu[k] = 1'b0;
            end else begin
                if (r_inc && !r_empty) begin
                    d  = m_mem[k][raddr];
                    kn = m_kn[k][raddr];
                    u  = !m_wr[k][raddr];
                    if (byp_of(k) && w_inc && !w_full && waddr == raddr && wm != 16'h0) begin
                        d  = (d & ~wm) | (wdata & wm);
                        kn = kn | wm;
                        u  = 1'b0;
                    end
                    e.due = cyc_n + lat_of(k) - 1; e.d = d; e.kn = kn; e.u = u;
                    pend[k].push_back(e);
                end
                if (pend[k].size() > 0 && pend[k][0].due == cyc_n) begin
                    e = pend[k].pop_front();
                    ev[k] = 1'b1; ed[k] = e.d; ek[k] = e.kn & dm; eu[k] = e.u;
                end else begin
                    ev[k] = 1'b0;
                end
                if (w_inc && !w_full) begin
                    m_mem[k][waddr] = (m_mem[k][waddr] & ~wm) | (wdata & wm);
                    m_kn[k][waddr]  = m_kn[k][waddr] | wm;
                    if (wm != 16'h0) m_wr[k][waddr] = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                logic        av, au;
                logic [15:0] ad;
                case (k)
                    0:       begin av = rvalid_a; ad = 16'(rdata_a); au = runinit_a; end
                    1:       begin av = rvalid_b; ad = rdata_b;      au = runinit_b; end
                    default: begin av = rvalid_c; ad = rdata_c;      au = runinit_c; end
                endcase
                check($sformatf("dut%0d rvalid", k), 16'(av), 16'(ev[k]), 16'h0001);
                check($sformatf("dut%0d rdata", k), ad, ed[k], ek[k]);
                if (ev[k]) check($sformatf("dut%0d r_uninit", k), 16'(au), 16'(eu[k]), 16'h0001);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_inc = 1'b0; w_full = 1'b0; r_inc = 1'b0; r_empty = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
        w_inc = 1'b1; waddr = a; wdata = d; wbe = be;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        r_inc = 1'b1; raddr = a;
    endtask

    function automatic logic [AW-1:0] pick();
        return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[k][a] = 16'h0; m_kn[k][a] = 16'h0; m_wr[k][a] = 1'b0;
            end
        idle(); w_rst = 1'b1; waddr = '0; raddr = '0; wdata = 16'h0; wbe = 2'b00;
        tick(); tick();
        lit("reset rvalid_a", 16'(rvalid_a), 16'h0);
        lit("reset rdata_a", 16'(rdata_a), 16'h0);
        lit("reset r_uninit_a", 16'(runinit_a), 16'h0);
        lit("reset rvalid_b", 16'(rvalid_b), 16'h0);
        w_rst = 1'b0; chk_en = 1'b1;

        // Never-written entry
        rd(5); tick(); idle();
        lit("t1 rvalid", 16'(rvalid_a), 16'h1);
        lit("t1 r_uninit", 16'(runinit_a), 16'h1);
        tick();
        lit("t1 single pulse", 16'(rvalid_a), 16'h0);

        // Write then read one cycle later
        wr(3, 16'h00A5, 2'b01); tick(); idle();
        rd(3); tick(); idle();
        lit("t2 rdata", 16'(rdata_a), 16'h00A5);
        lit("t2 r_uninit", 16'(runinit_a), 16'h0);

        // Partial-lane overwrite
        wr(7, 16'h1234, 2'b11); tick();
        wr(7, 16'hAB00, 2'b10); tick(); idle();
        rd(7); tick(); idle();
        lit("t3 rdata lat1", rdata_c, 16'hAB34);
        tick();
        lit("t3 rdata lat2", rdata_b, 16'hAB34);

        // Same-cycle read/write, write-first vs read-first
        wr(7, 16'hCDEF, 2'b01); rd(7); tick(); idle();
        lit("t4 bypass=1", rdata_c, 16'hABEF);
        tick();
        lit("t4 bypass=0", rdata_b, 16'hAB34);
        lit("t4 bypass=0 r_uninit", 16'(runinit_b), 16'h0);

        // Full blocks write, empty blocks read
        wr(2, 16'h0011, 2'b11); tick();
        wr(2, 16'hFFFF, 2'b11); w_full = 1'b1; tick(); idle();
        rd(2); tick(); idle();
        lit("t5 full a", 16'(rdata_a), 16'h0011);
        lit("t5 full c", rdata_c, 16'h0011);
        tick();
        lit("t5 full b", rdata_b, 16'h0011);
        rd(2); r_empty = 1'b1; tick(); idle();
        lit("t5 empty rvalid_a", 16'(rvalid_a), 16'h0);
        lit("t5 empty rdata hold", 16'(rdata_a), 16'h0011);
        tick();
        lit("t5 empty rvalid_b", 16'(rvalid_b), 16'h0);

        // Two-stage pipeline ordering, then flush by reset
        wr(0, 16'h0010, 2'b11); tick();
        wr(1, 16'h0011, 2'b11); tick();
        wr(2, 16'h0012, 2'b11); tick(); idle();
        rd(0); tick();
        lit("t6 not yet", 16'(rvalid_b), 16'h0);
        rd(1); tick();
        lit("t6 v0", 16'(rvalid_b), 16'h1); lit("t6 d0", rdata_b, 16'h0010);
        rd(2); tick(); idle();
        lit("t6 v1", 16'(rvalid_b), 16'h1); lit("t6 d1", rdata_b, 16'h0011);
        tick();
        lit("t6 v2", 16'(rvalid_b), 16'h1); lit("t6 d2", rdata_b, 16'h0012);
        tick();
        lit("t6 end", 16'(rvalid_b), 16'h0);
        rd(1); tick(); idle();
        w_rst = 1'b1; tick(); w_rst = 1'b0;
        lit("t6 flush rvalid", 16'(rvalid_b), 16'h0);
        lit("t6 flush rdata", rdata_b, 16'h0);
        tick();
        lit("t6 flush later rvalid", 16'(rvalid_b), 16'h0);
        lit("t6 flush later rdata", rdata_b, 16'h0);
        rd(0); tick(); idle();
        lit("bitmap cleared", 16'(runinit_c), 16'h1);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            w_rst   = ($urandom_range(0, 199) == 0);
            w_inc   = ($urandom_range(0, 3) != 0);
            w_full  = ($urandom_range(0, 7) == 0);
            r_inc   = ($urandom_range(0, 3) != 0);
            r_empty = ($urandom_range(0, 7) == 0);
            waddr   = pick();
            raddr   = ($urandom_range(0, 3) == 0) ? waddr : pick();
            wdata   = 16'($urandom);
            wbe     = 2'($urandom);
            tick();
        end
        w_rst = 1'b0; idle();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
